// File: rtl/external_interrupt_controller_pkg.sv
// Shared register offsets, FSM encoding and field positions for the external interrupt controller.
package external_interrupt_controller_pkg;

    localparam int unsigned EIC_IDX_W  = 5;
    localparam int unsigned EIC_OFFS_W = 3;

    localparam logic [EIC_OFFS_W-1:0] EIC_REG_PEND   = 3'd0;
    localparam logic [EIC_OFFS_W-1:0] EIC_REG_MASK   = 3'd1;
    localparam logic [EIC_OFFS_W-1:0] EIC_REG_PRIO   = 3'd2;
    localparam logic [EIC_OFFS_W-1:0] EIC_REG_ACTIVE = 3'd3;
    localparam logic [EIC_OFFS_W-1:0] EIC_REG_EOI    = 3'd4;
    localparam logic [EIC_OFFS_W-1:0] EIC_REG_SWSET  = 3'd5;

    localparam int unsigned EIC_ACTIVE_VALID = 31;

    typedef enum logic [1:0] {
        EIC_S_IDLE    = 2'd0,
        EIC_S_REQ     = 2'd1,
        EIC_S_SERVICE = 2'd2
    } eicState_t;

endpackage

// File: rtl/external_interrupt_controller_irq_edge_sync.sv
// Per-source 2-flop synchronizer with a rising-edge pulse on the synchronized value.
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic irqLine,
    output logic riseEdge_c
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= irqLine;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign riseEdge_c = sync2 & ~prev;

endmodule

// File: rtl/external_interrupt_controller.sv
// Memory-mapped external interrupt controller: edge capture, two-class priority
// arbitration and a request/service handshake with the core.
module external_interrupt_controller
    import external_interrupt_controller_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 8,
    parameter logic [29:0] BASE_ADDR = 30'h3FFF_FF00
) (
    input  logic               Sys_Clock,
    input  logic               Sys_Reset,
    input  logic [NUM_SRC-1:0] Src_Irq,
    input  logic               IO_EnR,
    input  logic               IO_EnW,
    input  logic [29:0]        IO_Address,
    input  logic [31:0]        IO_DataW,
    output logic [31:0]        IO_DataR,
    output logic               EIC_IntReq,
    output logic               EIC_IntId,
    input  logic               EIC_IntAck
);

    logic [NUM_SRC-1:0]   srcEdge;
    logic [NUM_SRC-1:0]   pend;
    logic [NUM_SRC-1:0]   mask;
    logic [NUM_SRC-1:0]   prio;
    logic [NUM_SRC-1:0]   pendNext;
    logic [NUM_SRC-1:0]   ackClr;
    logic [NUM_SRC-1:0]   w1cClr;
    logic [NUM_SRC-1:0]   swSet;
    logic [NUM_SRC-1:0]   candHi;
    logic [NUM_SRC-1:0]   candLo;
    logic [NUM_SRC-1:0]   cand;
    logic [31:0]          pendWide;
    logic [31:0]          maskWide;
    logic [31:0]          activeWord;
    logic [31:0]          readWord;
    logic [29:0]          offsFull;
    logic [EIC_OFFS_W-1:0] offs;
    logic                 hit;
    logic                 wrEoi;
    logic [EIC_IDX_W-1:0] selIdx;
    logic                 selCls;
    logic                 anyCand;
    logic [EIC_IDX_W-1:0] winIdx;
    logic                 winCls;
    logic                 activeValid;
    logic [EIC_IDX_W-1:0] activeIdx;
    logic                 latchWin;
    logic                 ackTake;
    logic                 eoiTake;
    eicState_t            state;
    eicState_t            stateNext;
    logic                 unusedOk;

    for (genvar g = 0; g < NUM_SRC; g++) begin : gSync
        irq_edge_sync uSync (
            .clk       (Sys_Clock),
            .rst       (Sys_Reset),
            .irqLine   (Src_Irq[g]),
            .riseEdge_c(srcEdge[g])
        );
    end

    assign offsFull = IO_Address - BASE_ADDR;
    assign hit      = (offsFull[29:EIC_OFFS_W] == '0);
    assign offs     = offsFull[EIC_OFFS_W-1:0];
    assign wrEoi    = IO_EnW & hit & (offs == EIC_REG_EOI);
    assign unusedOk = ^IO_DataW;

    assign pendWide = 32'(pend);
    assign maskWide = 32'(mask);

    // Class 1 beats class 0; within the chosen class the lowest index wins.
    always_comb begin
        candHi  = pend & mask & prio;
        candLo  = pend & mask & ~prio;
        anyCand = |(pend & mask);
        selCls  = |candHi;
        cand    = selCls ? candHi : candLo;
        selIdx  = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (cand[i]) selIdx = EIC_IDX_W'(i);
        end
    end

    always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
        if (Sys_Reset) state <= EIC_S_IDLE;
        else           state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        latchWin  = 1'b0;
        ackTake   = 1'b0;
        eoiTake   = 1'b0;
        case (state)
            EIC_S_IDLE: begin
                if (anyCand) begin
                    stateNext = EIC_S_REQ;
                    latchWin  = 1'b1;
                end
            end
            EIC_S_REQ: begin
                if (EIC_IntAck) begin
                    stateNext = EIC_S_SERVICE;
                    ackTake   = 1'b1;
                end else if (!pendWide[winIdx] || !maskWide[winIdx]) begin
                    stateNext = EIC_S_IDLE;
                end
            end
            EIC_S_SERVICE: begin
                if (wrEoi) begin
                    stateNext = EIC_S_IDLE;
                    eoiTake   = 1'b1;
                end
            end
            default: stateNext = EIC_S_IDLE;
        endcase
    end

    // Sets (edge or SWSET) override a same-cycle clear of the same bit.
    always_comb begin
        w1cClr   = (IO_EnW && hit && offs == EIC_REG_PEND)  ? IO_DataW[NUM_SRC-1:0] : '0;
        swSet    = (IO_EnW && hit && offs == EIC_REG_SWSET) ? IO_DataW[NUM_SRC-1:0] : '0;
        ackClr   = ackTake ? NUM_SRC'(32'd1 << winIdx) : '0;
        pendNext = (pend & ~(w1cClr | ackClr)) | srcEdge | swSet;
    end

    always_comb begin
        activeWord                   = '0;
        activeWord[EIC_ACTIVE_VALID] = activeValid;
        activeWord[EIC_IDX_W-1:0]    = activeIdx;
        case (offs)
            EIC_REG_PEND:   readWord = 32'(pend);
            EIC_REG_MASK:   readWord = 32'(mask);
            EIC_REG_PRIO:   readWord = 32'(prio);
            EIC_REG_ACTIVE: readWord = activeWord;
            default:        readWord = '0;
        endcase
    end

    always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
        if (Sys_Reset) begin
            pend        <= '0;
            mask        <= '0;
            prio        <= '0;
            winIdx      <= '0;
            winCls      <= 1'b0;
            activeValid <= 1'b0;
            activeIdx   <= '0;
            EIC_IntReq  <= 1'b0;
            EIC_IntId   <= 1'b0;
            IO_DataR    <= '0;
        end else begin
            pend <= pendNext;
            if (IO_EnW && hit && offs == EIC_REG_MASK) mask <= IO_DataW[NUM_SRC-1:0];
            if (IO_EnW && hit && offs == EIC_REG_PRIO) prio <= IO_DataW[NUM_SRC-1:0];
            if (latchWin) begin
                winIdx <= selIdx;
                winCls <= selCls;
            end
            if (ackTake) begin
                activeValid <= 1'b1;
                activeIdx   <= winIdx;
            end else if (eoiTake) begin
                activeValid <= 1'b0;
            end
            EIC_IntReq <= (stateNext == EIC_S_REQ);
            EIC_IntId  <= (stateNext == EIC_S_REQ) ? (latchWin ? selCls : winCls) : 1'b0;
            IO_DataR   <= (IO_EnR && hit) ? readWord : '0;
        end
    end

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Self-checking bench for external_interrupt_controller: directed scenarios plus
// randomized arbitration rounds checked against a priority-rule scoreboard.
module tb_external_interrupt_controller;

    localparam int unsigned NSRC = 8;
    localparam logic [29:0] BASE = 30'h3FFF_FF00;

    logic            Sys_Clock = 1'b0;
    logic            Sys_Reset = 1'b1;
    logic [NSRC-1:0] Src_Irq   = '0;
    logic            IO_EnR    = 1'b0;
    logic            IO_EnW    = 1'b0;
    logic [29:0]     IO_Address = BASE;
    logic [31:0]     IO_DataW  = '0;
    logic [31:0]     IO_DataR;
    logic            EIC_IntReq;
    logic            EIC_IntId;
    logic            EIC_IntAck = 1'b0;

    int checks = 0;
    int errors = 0;
    int lastIdx = 0;

    external_interrupt_controller #(.NUM_SRC(NSRC), .BASE_ADDR(BASE)) dut (
        .Sys_Clock (Sys_Clock),
        .Sys_Reset (Sys_Reset),
        .Src_Irq   (Src_Irq),
        .IO_EnR    (IO_EnR),
        .IO_EnW    (IO_EnW),
        .IO_Address(IO_Address),
        .IO_DataW  (IO_DataW),
        .IO_DataR  (IO_DataR),
        .EIC_IntReq(EIC_IntReq),
        .EIC_IntId (EIC_IntId),
        .EIC_IntAck(EIC_IntAck)
    );

    always #5 Sys_Clock = ~Sys_Clock;

    task automatic tick();
        @(posedge Sys_Clock);
        #1;
    endtask

    task automatic ioWrite(input int unsigned off, input logic [31:0] d);
        IO_Address = BASE + 30'(off);
        IO_DataW   = d;
        IO_EnW     = 1'b1;
        tick();
        IO_EnW     = 1'b0;
    endtask

    task automatic ioRead(input int unsigned off, output logic [31:0] d);
        IO_Address = BASE + 30'(off);
        IO_EnR     = 1'b1;
        tick();
        IO_EnR     = 1'b0;
        d          = IO_DataR;
    endtask

    task automatic waitReq(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (EIC_IntReq) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic ackOnce();
        EIC_IntAck = 1'b1;
        tick();
        EIC_IntAck = 1'b0;
    endtask

    // Spec rule: any class-1 candidate beats class 0; lowest index within the class.
    function automatic int pickIdx(input logic [NSRC-1:0] c, input logic [NSRC-1:0] p);
        logic [NSRC-1:0] pool;
        pool = ((c & p) != 0) ? (c & p) : (c & ~p);
        for (int i = 0; i < int'(NSRC); i++) if (pool[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        Sys_Reset = 1'b1;
        tick(); tick();
        checks++;
        if ({EIC_IntReq, EIC_IntId, IO_DataR} !== 34'd0) begin
            errors++; $display("FAIL reset_outputs: got req=%b id=%b data=%h, want 0", EIC_IntReq, EIC_IntId, IO_DataR);
        end
        Sys_Reset = 1'b0;
        tick();
        for (int off = 0; off < 4; off++) begin
            ioRead(off, d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h, want 0", off, d); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        ioWrite(1, 32'h01);
        Src_Irq[0] = 1'b1;
        tick(); tick();
        checks++;
        if (EIC_IntReq !== 1'b0) begin errors++; $display("FAIL basic_early1: req=%b want 0", EIC_IntReq); end
        tick();
        checks++;
        if (EIC_IntReq !== 1'b0) begin errors++; $display("FAIL basic_early2: req=%b want 0", EIC_IntReq); end
        ioRead(0, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL basic_pend: got %h want 00000001", d); end
        checks++;
        if ({EIC_IntReq, EIC_IntId} !== 2'b10) begin errors++; $display("FAIL basic_req: req/id=%b%b want 10", EIC_IntReq, EIC_IntId); end
        ackOnce();
        checks++;
        if (EIC_IntReq !== 1'b0) begin errors++; $display("FAIL basic_ack_drop: req=%b want 0", EIC_IntReq); end
        ioRead(0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL basic_pend_clr: got %h want 0", d); end
        ioRead(3, d);
        checks++;
        if (d !== 32'h8000_0000) begin errors++; $display("FAIL basic_active: got %h want 80000000", d); end
        lastIdx = 0;
        Src_Irq[0] = 1'b0;
        ioWrite(4, 32'h0);
        ioRead(3, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL basic_eoi: got %h want 0", d); end
        checks++;
        if (EIC_IntReq !== 1'b0) begin errors++; $display("FAIL basic_idle: req=%b want 0", EIC_IntReq); end
        repeat (4) tick();
    endtask

    task automatic test_prio();
        logic [31:0] d;
        bit got;
        ioWrite(1, 32'hFF);
        ioWrite(2, 32'h10);
        Src_Irq = 8'h14;
        waitReq(got);
        checks++;
        if (!got || EIC_IntId !== 1'b1) begin errors++; $display("FAIL prio_first: got=%0d id=%b want 1,1", got, EIC_IntId); end
        ackOnce();
        ioRead(3, d);
        checks++;
        if (d !== 32'h8000_0004) begin errors++; $display("FAIL prio_active4: got %h want 80000004", d); end
        ioWrite(4, 32'h0);
        waitReq(got);
        checks++;
        if (!got || EIC_IntId !== 1'b0) begin errors++; $display("FAIL prio_second: got=%0d id=%b want 1,0", got, EIC_IntId); end
        ackOnce();
        ioRead(3, d);
        checks++;
        if (d !== 32'h8000_0002) begin errors++; $display("FAIL prio_active2: got %h want 80000002", d); end
        lastIdx = 2;
        ioWrite(4, 32'h0);
        Src_Irq = '0;
        repeat (4) tick();
    endtask

    task automatic test_withdraw();
        logic [31:0] d;
        bit got;
        ioWrite(1, 32'h08);
        Src_Irq[3] = 1'b1;
        waitReq(got);
        checks++;
        if (!got) begin errors++; $display("FAIL withdraw_req: no request, want req"); end
        ioWrite(0, 32'h08);
        checks++;
        if (EIC_IntReq !== 1'b1) begin errors++; $display("FAIL withdraw_hold: req=%b want 1", EIC_IntReq); end
        tick();
        checks++;
        if (EIC_IntReq !== 1'b0) begin errors++; $display("FAIL withdraw_drop: req=%b want 0", EIC_IntReq); end
        repeat (3) tick();
        ioRead(3, d);
        checks++;
        if (d !== 32'(lastIdx) || EIC_IntReq !== 1'b0) begin
            errors++; $display("FAIL withdraw_active: got %h req=%b want %h req=0", d, EIC_IntReq, 32'(lastIdx));
        end
        Src_Irq = '0;
        repeat (4) tick();
    endtask

    task automatic test_ack_collision();
        logic [31:0] d;
        bit got;
        ioWrite(1, 32'h0);
        Src_Irq[1] = 1'b1;
        repeat (4) tick();
        Src_Irq[1] = 1'b0;
        repeat (4) tick();
        ioWrite(1, 32'h02);
        tick();
        checks++;
        if (EIC_IntReq !== 1'b1) begin errors++; $display("FAIL coll_req: req=%b want 1", EIC_IntReq); end
        Src_Irq[1] = 1'b1;
        tick(); tick();
        ackOnce();
        checks++;
        if (EIC_IntReq !== 1'b0) begin errors++; $display("FAIL coll_ack: req=%b want 0", EIC_IntReq); end
        ioRead(0, d);
        checks++;
        if (d !== 32'h02) begin errors++; $display("FAIL coll_pend: got %h want 00000002", d); end
        ioRead(3, d);
        checks++;
        if (d !== 32'h8000_0001) begin errors++; $display("FAIL coll_active: got %h want 80000001", d); end
        ioWrite(4, 32'h0);
        checks++;
        if (EIC_IntReq !== 1'b0) begin errors++; $display("FAIL coll_eoi_gap: req=%b want 0", EIC_IntReq); end
        tick();
        checks++;
        if ({EIC_IntReq, EIC_IntId} !== 2'b10) begin errors++; $display("FAIL coll_rereq: req/id=%b%b want 10", EIC_IntReq, EIC_IntId); end
        ackOnce();
        ioWrite(4, 32'h0);
        lastIdx = 1;
        Src_Irq = '0;
        repeat (4) tick();
        waitReq(got);
        checks++;
        if (got) begin errors++; $display("FAIL coll_quiet: req=1 want 0"); end
    endtask

    task automatic test_swset_and_map();
        logic [31:0] d;
        bit got;
        ioWrite(1, 32'h80);
        ioWrite(5, 32'h80);
        waitReq(got);
        checks++;
        if (!got || EIC_IntId !== 1'b0) begin errors++; $display("FAIL swset_req: got=%0d id=%b want 1,0", got, EIC_IntId); end
        ackOnce();
        ioRead(3, d);
        checks++;
        if (d !== 32'h8000_0007) begin errors++; $display("FAIL swset_active: got %h want 80000007", d); end
        lastIdx = 7;
        ioWrite(4, 32'h0);
        ioWrite(6, 32'hFFFF_FFFF);
        ioWrite(9, 32'hFFFF_FFFF);
        ioRead(1, d);
        for (int off = 6; off < 10; off++) begin
            ioRead(off, d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL unmapped_off%0d: got %h want 0", off, d); end
        end
        ioRead(1, d);
        checks++;
        if (d !== 32'h80) begin errors++; $display("FAIL unmapped_write: mask=%h want 00000080", d); end
        tick();
        checks++;
        if (IO_DataR !== 32'h0) begin errors++; $display("FAIL read_idle: got %h want 0", IO_DataR); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [NSRC-1:0] s, w, m, p, pendM;
        bit got;
        int idx;
        bit cls;
        for (int it = 0; it < 16; it++) begin
            s = NSRC'($urandom_range(1, 255));
            w = NSRC'($urandom);
            m = NSRC'($urandom);
            p = NSRC'($urandom);
            ioWrite(1, 32'h0);
            ioWrite(2, 32'(p));
            Src_Irq = s;
            ioWrite(5, 32'(w));
            repeat (5) tick();
            pendM = s | w;
            ioRead(0, d);
            checks++;
            if (d !== 32'(pendM)) begin errors++; $display("FAIL rand%0d_pend: got %h want %h", it, d, 32'(pendM)); end
            ioWrite(1, 32'(m));
            while ((pendM & m) != 0) begin
                idx = pickIdx(pendM & m, p);
                cls = ((pendM & m & p) != 0);
                waitReq(got);
                checks++;
                if (!got || EIC_IntId !== cls) begin
                    errors++; $display("FAIL rand%0d_req: got=%0d id=%b want 1,%b", it, got, EIC_IntId, cls);
                end
                ackOnce();
                ioRead(3, d);
                checks++;
                if (d !== (32'h8000_0000 | 32'(idx))) begin
                    errors++; $display("FAIL rand%0d_active: got %h want %h", it, d, 32'h8000_0000 | 32'(idx));
                end
                lastIdx = idx;
                pendM[idx] = 1'b0;
                ioWrite(4, 32'h0);
                if (!got) break;
            end
            repeat (3) tick();
            ioRead(0, d);
            checks++;
            if (d !== 32'(pendM) || EIC_IntReq !== 1'b0) begin
                errors++; $display("FAIL rand%0d_rest: pend=%h req=%b want %h,0", it, d, EIC_IntReq, 32'(pendM));
            end
            Src_Irq = '0;
            ioWrite(0, 32'hFFFF_FFFF);
            repeat (4) tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit got;
        ioWrite(1, 32'h01);
        ioWrite(5, 32'h01);
        waitReq(got);
        #2 Sys_Reset = 1'b1;
        #1;
        checks++;
        if (!got || EIC_IntReq !== 1'b0) begin errors++; $display("FAIL rst_req: got=%0d req=%b want 1,0", got, EIC_IntReq); end
        tick();
        Sys_Reset = 1'b0;
        tick();
        ioWrite(1, 32'h01);
        ioWrite(5, 32'h01);
        waitReq(got);
        ackOnce();
        Src_Irq[5] = 1'b1;
        IO_Address = BASE + 30'd3;
        IO_EnR = 1'b1;
        tick();
        checks++;
        if (IO_DataR !== 32'h8000_0000) begin errors++; $display("FAIL rst_pre_active: got %h want 80000000", IO_DataR); end
        #2 Sys_Reset = 1'b1;
        #1;
        checks++;
        if (IO_DataR !== 32'h0 || EIC_IntReq !== 1'b0) begin
            errors++; $display("FAIL rst_service: data=%h req=%b want 0,0", IO_DataR, EIC_IntReq);
        end
        IO_EnR = 1'b0;
        tick(); tick();
        Sys_Reset = 1'b0;
        repeat (4) tick();
        ioRead(0, d);
        checks++;
        if (d !== 32'h20) begin errors++; $display("FAIL rst_held_line: pend=%h want 00000020", d); end
        ioRead(1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_mask: got %h want 0", d); end
        ioRead(3, d);
        checks++;
        if (d !== 32'h0 || EIC_IntReq !== 1'b0) begin errors++; $display("FAIL rst_active: got %h req=%b want 0,0", d, EIC_IntReq); end
        Src_Irq = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prio();
        test_withdraw();
        test_ack_collision();
        test_swset_and_map();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
